// File: rtl/fetch_queue_pkg.sv
// Fetch-queue local definitions.
//   fq_op_e          : per-cycle queue operation, encoded as {enqueue, dequeue}
//   FQ_DEFAULT_WIDTH : default instruction width
//   FQ_DEFAULT_CNT_W : default width of the full-cycle performance counter
package fetch_queue_pkg;

    localparam int FQ_DEFAULT_WIDTH = 16;
    localparam int FQ_DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        FQ_OP_NONE = 2'b00,
        FQ_OP_DEQ  = 2'b01,
        FQ_OP_ENQ  = 2'b10,
        FQ_OP_BOTH = 2'b11
    } fq_op_e;

endpackage : fetch_queue_pkg

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions.
//   lc3b_word        : 16-bit machine word (PC values, instructions)
//   FQ_DEFAULT_DEPTH : default entry count of the fetch queue
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int FQ_DEFAULT_DEPTH = 4;

endpackage : lc3b_types

// File: rtl/fetch_queue_if.sv
// Fetch queue handshake bundle.
//   enq_* : fetch side pushes instruction + PC+2, queue answers enq_ready
//   deq_* : queue presents head entry, decode answers deq_ready
// Modports: master = fetch/decode environment, slave = the queue.
interface fetch_queue_if
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
);
    logic             enq_valid;
    logic [WIDTH-1:0] enq_instr;
    lc3b_word         enq_pc_plus2;
    logic             enq_ready;
    logic             deq_valid;
    logic [WIDTH-1:0] deq_instr;
    lc3b_word         deq_pc_plus2;
    logic             deq_ready;

    modport master (
        output enq_valid, enq_instr, enq_pc_plus2, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc_plus2
    );

    modport slave (
        input  enq_valid, enq_instr, enq_pc_plus2, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc_plus2
    );
endinterface : fetch_queue_if

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
//   clk       : clock
//   reset_sig : synchronous active-low reset (value -> 0)
//   inc       : count one event this cycle
//   clear     : synchronous clear, wins over inc
//   value     : current count, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_sig,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value
);
    logic [W-1:0] value_r;

    // Counter register: reset, clear, saturating increment.
    always_ff @(posedge clk) begin
        if (!reset_sig) begin
            value_r <= {W{1'b0}};
        end else if (clear) begin
            value_r <= {W{1'b0}};
        end else if (inc && (value_r != {W{1'b1}})) begin
            value_r <= value_r + W'(1);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
endmodule : sat_counter

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID.
//   clk         : clock
//   reset_sig   : synchronous active-low reset, overrides everything
//   flush       : squash all queued entries (wins over enq/deq)
//   bus         : enq/deq handshake (fetch_queue_if.slave)
//   count       : current occupancy
//   full_cycles : saturating count of cycles spent full (survives flush)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_queue
    import lc3b_types::*;
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    parameter int WIDTH = FQ_DEFAULT_WIDTH,
    parameter int CNT_W = FQ_DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_sig,
    input  logic                     flush,
    fetch_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         full_cycles
);
    localparam int                  PTR_W      = $clog2(DEPTH);
    localparam int                  CNT_BITS   = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    instr_mem_r [DEPTH];
    lc3b_word            pc_mem_r    [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_BITS-1:0] count_r;
    logic                enq_ready_r;
    logic                deq_valid_r;

    logic [PTR_W-1:0]    wr_ptr_next_s;
    logic [PTR_W-1:0]    rd_ptr_next_s;
    logic [CNT_BITS-1:0] count_next_s;
    logic                enq_fire_s;
    logic                deq_fire_s;
    logic                full_s;
    fq_op_e              op_s;

    // enq_ready is registered as (count != DEPTH), so a full queue never
    // accepts even when the head is being consumed in the same cycle.
    assign enq_fire_s = bus.enq_valid & enq_ready_r & ~flush;
    assign deq_fire_s = deq_valid_r & bus.deq_ready & ~flush;
    assign op_s       = fq_op_e'({enq_fire_s, deq_fire_s});
    assign full_s     = (count_r == FULL_COUNT);

    // Next pointer/occupancy; flush empties the queue and drops enq/deq.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (flush) begin
            wr_ptr_next_s = {PTR_W{1'b0}};
            rd_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_BITS{1'b0}};
        end else begin
            case (op_s)
                FQ_OP_ENQ: begin
                    wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
                    count_next_s  = count_r + CNT_BITS'(1);
                end
                FQ_OP_DEQ: begin
                    rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
                    count_next_s  = count_r - CNT_BITS'(1);
                end
                FQ_OP_BOTH: begin
                    wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
                    rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
                end
                FQ_OP_NONE: begin
                    count_next_s  = count_r;
                end
                default: begin
                    count_next_s  = count_r;
                end
            endcase
        end
    end

    // Control state; status flags are registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (!reset_sig) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_BITS{1'b0}};
            enq_ready_r <= 1'b1;
            deq_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            enq_ready_r <= (count_next_s != FULL_COUNT);
            deq_valid_r <= (count_next_s != {CNT_BITS{1'b0}});
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            instr_mem_r[wr_ptr_r] <= bus.enq_instr;
            pc_mem_r[wr_ptr_r]    <= bus.enq_pc_plus2;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_full_cnt (
        .clk       (clk),
        .reset_sig (reset_sig),
        .inc       (full_s),
        .clear     (1'b0),
        .value     (full_cycles)
    );

    // Head comes straight from storage: no enq->deq bypass.
    assign bus.enq_ready    = enq_ready_r;
    assign bus.deq_valid    = deq_valid_r;
    assign bus.deq_instr    = instr_mem_r[rd_ptr_r];
    assign bus.deq_pc_plus2 = pc_mem_r[rd_ptr_r];
    assign count            = count_r;
endmodule : fetch_queue
